// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the three-digit multiplexed display scanner.
// Digit select and anode encodings live here so the scanner and any consumer agree.
package display_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_e;

   localparam logic [1:0] SEL_HUN  = 2'b00;
   localparam logic [1:0] SEL_TEN  = 2'b01;
   localparam logic [1:0] SEL_ONE  = 2'b10;
   localparam logic [1:0] SEL_NONE = 2'b11;

   localparam logic [2:0] AN_HUN = 3'b011;
   localparam logic [2:0] AN_TEN = 3'b101;
   localparam logic [2:0] AN_ONE = 3'b110;
   localparam logic [2:0] AN_OFF = 3'b111;

   function automatic logic [1:0] next_sel(input logic [1:0] sel);
      case (sel)
         SEL_HUN: next_sel = SEL_TEN;
         SEL_TEN: next_sel = SEL_ONE;
         default: next_sel = SEL_HUN;
      endcase
   endfunction

   function automatic logic [2:0] sel_anode(input logic [1:0] sel);
      case (sel)
         SEL_HUN: sel_anode = AN_HUN;
         SEL_TEN: sel_anode = AN_TEN;
         SEL_ONE: sel_anode = AN_ONE;
         default: sel_anode = AN_OFF;
      endcase
   endfunction

   function automatic logic [3:0] pick_nib(input logic [11:0] v, input logic [1:0] sel);
      case (sel)
         SEL_HUN: pick_nib = v[11:8];
         SEL_TEN: pick_nib = v[7:4];
         SEL_ONE: pick_nib = v[3:0];
         default: pick_nib = 4'h0;
      endcase
   endfunction

   // Non-decimal nibbles are shown as F so a corrupt value is visibly wrong.
   function automatic logic [3:0] nib_out(input logic [3:0] n);
      nib_out = (n > 4'd9) ? 4'hF : n;
   endfunction

   function automatic logic bcd_bad(input logic [11:0] v);
      bcd_bad = (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
   endfunction

endpackage

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// Slot timer: counts 0..PRESCALE-1 while the scanner runs, cleared otherwise.
// pre_end_o marks the cycle before slot end so the top can register frame_tick.
module scan_prescaler #(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 500
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run_i,
   output logic blank_end_o,
   output logic pre_end_o,
   output logic slot_end_o
);

   localparam int CW = $clog2(PRESCALE);

   logic [CW-1:0] cnt_q, cnt_d;

   assign blank_end_o = (cnt_q == CW'(BLANK - 1));
   assign pre_end_o   = (cnt_q == CW'(PRESCALE - 2));
   assign slot_end_o  = (cnt_q == CW'(PRESCALE - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (!run_i || slot_end_o) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Three-digit BCD display scanner with blanking, leading-zero suppression and a
// single-entry pending buffer that is swapped into the display only at frame end.
module display_scan_ctrl
   import display_scan_ctrl_pkg::*;
#(
   parameter int PRESCALE = 50000,
   parameter int BLANK    = 500,
   parameter int LZ_EN    = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [11:0] bcd_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [1:0]  selec,
   output logic [2:0]  an,
   output logic [3:0]  digit,
   output logic        frame_tick,
   output logic        bcd_err
);

   state_e      state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [2:0]  an_q, an_d;
   logic [3:0]  digit_q, digit_d;
   logic        ft_q, ft_d, err_q, err_d, rdy_q, rdy_d;
   logic [11:0] pend_q, pend_d, disp_q, disp_d;
   logic        pend_full_q, pend_full_d;
   logic        blank_end, pre_end, slot_end, accept, supp;

   scan_prescaler #(.PRESCALE(PRESCALE), .BLANK(BLANK)) u_presc (
      .clk        (clk),
      .rst_n      (rst_n),
      .run_i      (en && (state_q != ST_IDLE)),
      .blank_end_o(blank_end),
      .pre_end_o  (pre_end),
      .slot_end_o (slot_end)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      unique case (state_q)
         ST_IDLE:  begin
            state_d = ST_BLANK;
            sel_d   = SEL_HUN;
         end
         ST_BLANK: if (blank_end) state_d = ST_SHOW;
         ST_SHOW:  if (slot_end) begin
            state_d = ST_BLANK;
            sel_d   = next_sel(sel_q);
         end
         default:  state_d = ST_IDLE;
      endcase
      if (!en) begin
         state_d = ST_IDLE;
         sel_d   = SEL_NONE;
      end
   end

   // Pending swaps into the display only in the frame_tick cycle.
   always_comb begin
      accept      = in_valid && rdy_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      disp_d      = disp_q;
      if (ft_q && pend_full_q) begin
         disp_d      = pend_q;
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pend_d      = bcd_in;
         pend_full_d = 1'b1;
      end
      rdy_d = !pend_full_d;
      err_d = accept && bcd_bad(bcd_in);
   end

   // Outputs are derived from next-state values so an, selec and digit move together.
   always_comb begin
      supp = (LZ_EN != 0) &&
             (((sel_d == SEL_HUN) && (disp_d[11:8] == 4'h0)) ||
              ((sel_d == SEL_TEN) && (disp_d[11:4] == 8'h00)));
      an_d    = ((state_d == ST_SHOW) && !supp) ? sel_anode(sel_d) : AN_OFF;
      digit_d = (state_d == ST_IDLE) ? 4'h0 : nib_out(pick_nib(disp_d, sel_d));
      ft_d    = en && (state_q == ST_SHOW) && (sel_q == SEL_ONE) && pre_end;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sel_q       <= SEL_NONE;
         an_q        <= AN_OFF;
         digit_q     <= 4'h0;
         ft_q        <= 1'b0;
         err_q       <= 1'b0;
         rdy_q       <= 1'b1;
         pend_q      <= 12'h000;
         pend_full_q <= 1'b0;
         disp_q      <= 12'h000;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         an_q        <= an_d;
         digit_q     <= digit_d;
         ft_q        <= ft_d;
         err_q       <= err_d;
         rdy_q       <= rdy_d;
         pend_q      <= pend_d;
         pend_full_q <= pend_full_d;
         disp_q      <= disp_d;
      end
   end

   assign selec      = sel_q;
   assign an         = an_q;
   assign digit      = digit_q;
   assign frame_tick = ft_q;
   assign bcd_err    = err_q;
   assign in_ready   = rdy_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl: a frame-position reference model queues the
// expected outputs each edge; a negedge monitor pops and compares against the DUT.
module tb_display_scan_ctrl;

   localparam int P = 8;
   localparam int B = 2;
   localparam int FRAME = 3 * P;

   typedef struct packed {
      logic [2:0] an;
      logic [1:0] selec;
      logic [3:0] digit;
      logic       ft;
      logic       err;
      logic       rdy;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [11:0] bcd_in = 12'h000;
   logic        in_valid = 1'b0;
   logic        in_ready, frame_tick, bcd_err;
   logic [1:0]  selec;
   logic [2:0]  an;
   logic [3:0]  digit;

   int n_chk = 0;
   int n_fail = 0;
   bit armed = 1'b0;
   exp_t expq[$];

   display_scan_ctrl #(.PRESCALE(P), .BLANK(B), .LZ_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .bcd_in(bcd_in), .in_valid(in_valid),
      .in_ready(in_ready), .selec(selec), .an(an), .digit(digit),
      .frame_tick(frame_tick), .bcd_err(bcd_err)
   );

   always #5 clk = ~clk;

   // Reference model: p is the position within the scan frame (-1 when stopped).
   int          p;
   logic [11:0] m_disp, m_pend;
   bit          m_full, m_rdy, m_err;

   function automatic bit has_bad(input logic [11:0] v);
      return (v[11:8] > 9) || (v[7:4] > 9) || (v[3:0] > 9);
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      logic [2:0] anodes [3];
      logic [3:0] nib;
      int slot, off;
      bit hidden;
      anodes = '{3'b011, 3'b101, 3'b110};
      e.err = m_err;
      e.rdy = m_rdy;
      if (p < 0) begin
         e.an = 3'b111; e.selec = 2'b11; e.digit = 4'h0; e.ft = 1'b0;
      end else begin
         slot = p / P;
         off  = p % P;
         nib  = (slot == 0) ? m_disp[11:8] : (slot == 1) ? m_disp[7:4] : m_disp[3:0];
         hidden = (slot == 0 && m_disp[11:8] == 0) || (slot == 1 && m_disp[11:4] == 0);
         e.selec = 2'(slot);
         e.digit = (nib > 9) ? 4'hF : nib;
         e.an    = (off >= B && !hidden) ? anodes[slot] : 3'b111;
         e.ft    = (p == FRAME - 1);
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin : model
      bit tick, acc;
      if (!rst_n) begin
         p = -1; m_disp = 12'h000; m_pend = 12'h000;
         m_full = 1'b0; m_rdy = 1'b1; m_err = 1'b0;
         expq.delete();
         expq.push_back(model_out());
      end else begin
         tick = (p == FRAME - 1);
         acc  = in_valid && m_rdy;
         if (tick && m_full) begin
            m_disp = m_pend;
            m_full = 1'b0;
         end
         if (acc) begin
            m_pend = bcd_in;
            m_full = 1'b1;
         end
         m_err = acc && has_bad(bcd_in);
         m_rdy = !m_full;
         if (!en) p = -1;
         else     p = (p < 0) ? 0 : (p + 1) % FRAME;
         expq.push_back(model_out());
      end
      if (clk) armed = 1'b1;
   end

   always @(negedge clk) begin
      exp_t e, g;
      if (armed) begin
         n_chk++;
         if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t: no expected entry queued", $time);
         end else begin
            e = expq.pop_front();
            g = '{an: an, selec: selec, digit: digit, ft: frame_tick, err: bcd_err, rdy: in_ready};
            if (g !== e) begin
               n_fail++;
               $display("FAIL outputs t=%0t: got an=%b selec=%b digit=%h ft=%b err=%b rdy=%b, want an=%b selec=%b digit=%h ft=%b err=%b rdy=%b",
                        $time, g.an, g.selec, g.digit, g.ft, g.err, g.rdy,
                        e.an, e.selec, e.digit, e.ft, e.err, e.rdy);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [11:0] v);
      @(posedge clk); #1;
      in_valid = 1'b1; bcd_in = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Bounded wait for a given selec/an combination, sampled on the falling edge.
   task automatic wait_show(input logic [1:0] s, input logic [2:0] a, input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (selec === s && an === a) hit = 1'b1;
      end
      n_chk++;
      if (!hit) begin
         n_fail++;
         $display("FAIL %s: timeout, got selec=%b an=%b, want selec=%b an=%b", name, selec, an, s, a);
      end
   endtask

   task automatic wait_tick(input string name);
      bit hit = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge clk);
         if (frame_tick === 1'b1) hit = 1'b1;
      end
      n_chk++;
      if (!hit) begin
         n_fail++;
         $display("FAIL %s: timeout, got frame_tick=%b, want 1", name, frame_tick);
      end
   endtask

   task automatic check_reset_now();
      n_chk++;
      if ({an, selec, digit, frame_tick, bcd_err, in_ready} !== {3'b111, 2'b11, 4'h0, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_async: got an=%b selec=%b digit=%h ft=%b err=%b rdy=%b, want 111 11 0 0 0 1",
                  an, selec, digit, frame_tick, bcd_err, in_ready);
      end
   endtask

   function automatic logic [11:0] rand_bcd();
      int r = $urandom_range(0, 7);
      logic [3:0] h = 4'($urandom_range(0, 9));
      logic [3:0] t = 4'($urandom_range(0, 9));
      logic [3:0] o = 4'($urandom_range(0, 9));
      if (r == 0) return 12'($urandom);
      if (r == 1) return {8'h00, o};
      if (r == 2) return {4'h0, t, o};
      return {h, t, o};
   endfunction

   initial begin
      cycles(3);
      rst_n = 1'b1;
      cycles(3);
      en = 1'b1;
      offer(12'h123);
      cycles(3 * FRAME);
      offer(12'h007);
      cycles(2 * FRAME + 4);
      offer(12'h123);
      cycles(2 * FRAME);
      cycles(10);
      offer(12'h456);
      in_valid = 1'b1; bcd_in = 12'h789;
      cycles(2 * FRAME);
      in_valid = 1'b0;
      cycles(2 * FRAME);
      offer(12'h1A3);
      cycles(2 * FRAME + 4);
      wait_show(2'b01, 3'b101, "tens_show");
      en = 1'b0;
      cycles(4);
      en = 1'b1;
      cycles(FRAME + 6);
      wait_tick("frame_tick_seen");
      offer(12'h999);
      wait_show(2'b10, 3'b110, "ones_show");
      #2 rst_n = 1'b0;
      #1 check_reset_now();
      cycles(2);
      rst_n = 1'b1;
      cycles(2 * FRAME);

      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 149) == 0) en = ~en;
         in_valid = ($urandom_range(0, 3) == 0);
         bcd_in = rand_bcd();
         if ($urandom_range(0, 799) == 0) begin
            rst_n = 1'b0;
            #1 check_reset_now();
            cycles(2);
            rst_n = 1'b1;
         end
      end
      in_valid = 1'b0;
      cycles(3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 50000, sets clock cycles per digit slot; legal range 4..2^20.
REQ-002 Parameter BLANK, default 500, sets inter-digit blanking cycles at slot start; legal range 1..PRESCALE-2.
REQ-003 Parameter LZ_EN, default 1; 1 enables leading-zero suppression.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 en  in  1  scan enable; 0 blanks the display.
REQ-007 bcd_in  in  12  [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-008 in_valid  in  1  bcd_in offered.
REQ-009 in_ready  out  1  pending buffer empty, can accept a value.
REQ-010 selec  out  2  digit select to the display mux: 00 hundreds, 01 tens, 10 ones, 11 none.
REQ-011 an  out  3  active-low anodes: 011 hundreds, 101 tens, 110 ones, 111 all off.
REQ-012 digit  out  4  BCD code of the selected digit.
REQ-013 frame_tick  out  1  one-cycle pulse at the end of each full scan frame.
REQ-014 bcd_err  out  1  one-cycle pulse when an accepted value contains a nibble >9.

Function
REQ-015 All outputs SHALL be registered; an, selec and digit SHALL change on the same clock edge.
REQ-016 FSM states SHALL be IDLE, BLANK and SHOW.
REQ-017 While en=0, the FSM SHALL be in IDLE with an=111, selec=11, digit=0 and the slot counter cleared.
REQ-018 On en=1 in IDLE, the FSM SHALL enter BLANK for hundreds on the next edge.
REQ-019 Each slot SHALL last exactly PRESCALE cycles: BLANK cycles in BLANK (an=111, selec still driven with the upcoming digit), then PRESCALE-BLANK cycles in SHOW with that digit's anode low.
REQ-020 At slot end, the FSM SHALL go to BLANK of the next digit in the order hundreds, tens, ones, and wrap from ones to hundreds without an idle cycle.
REQ-021 frame_tick SHALL pulse during the last SHOW cycle of the ones slot.
REQ-022 Accept SHALL occur when in_valid and in_ready are both 1: bcd_in is written to the pending register and in_ready falls on the next edge.
REQ-023 In the frame_tick cycle, if pending is full, pending SHALL copy to the display register and in_ready SHALL rise on the next edge; the displayed value changes only at frame boundaries.
REQ-024 An accept in the frame_tick cycle while pending is empty SHALL go to pending and be displayed after the following frame.
REQ-025 With LZ_EN=1:
- hundreds=0 SHALL keep an=111 for that slot.
- tens SHALL be likewise blanked when both hundreds and tens are 0.
- ones SHALL never be suppressed.
REQ-026 Any displayed nibble >9 SHALL drive digit=4'hF; bcd_err SHALL pulse in the cycle after the accept.
REQ-027 When en falls mid-slot, the FSM SHALL reach IDLE on the next edge; pending and display registers SHALL be retained, and frame_tick SHALL not pulse.

Reset
REQ-028 While rst_n=0, outputs SHALL be: an=111, selec=11, digit=0, frame_tick=0, bcd_err=0, in_ready=1.
REQ-029 Reset SHALL set state=IDLE, counter=0, pending empty and display register=0.
REQ-030 Reset deassertion SHALL take effect on the first clk edge with rst_n=1; a reset mid-frame SHALL discard pending data.

Structure
REQ-031 A shared package SHALL hold:
- the state enum (IDLE/BLANK/SHOW);
- the digit-select constants SEL_HUN=00, SEL_TEN=01, SEL_ONE=10, SEL_NONE=11;
- the matching anode constants.
REQ-032 One sub-module, scan_prescaler, SHALL hold the slot counter and emit the blank_end and slot_end strobes.

Verification (PRESCALE=8, BLANK=2)
REQ-033 en=1, accept 0x123 then wait one frame -> per 8-cycle slot, 2 cycles an=111 then 6 cycles an=011/digit 1, 101/2, 110/3; frame_tick every 24 cycles.
REQ-034 Display 0x007 with LZ_EN=1 -> hundreds and tens slots keep an=111; ones slot shows an=110, digit 7.
REQ-035 Accept 0x456 mid-frame while 0x123 is shown -> in_ready=0 until the frame_tick cycle; 456 first visible in the next hundreds SHOW; a second offer is held off until then.
REQ-036 Accept 0x1A3 -> bcd_err pulses once; tens slot shows digit F.
REQ-037 en=0 during tens SHOW -> next edge an=111, selec=11, no frame_tick; en=1 restarts at hundreds BLANK with the value retained.
REQ-038 rst_n low during ones SHOW with pending full -> all outputs at reset values immediately; after release in_ready=1 and the display shows 000 (suppressed to a lone ones 0).
